// File: rtl/hamming_serial_rx_if.sv
// Output handshake bundle for hamming_serial_rx: corrected nibble plus status
// flags, drained over valid/ready.
interface hamming_serial_rx_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_corrected;
  logic       out_error;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_corrected,
    output out_error
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_corrected,
    input  out_error
  );
endinterface

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) frame receiver with single-error correction, output FIFO
// and link statistics. Define HAMMING_SECDED_EN for the 8-bit SECDED frame.
module hamming_serial_rx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             serial_in,
  input  logic             clr_cnt,
  hamming_serial_rx_if.master dout,
  output logic             overflow,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

`ifdef HAMMING_SECDED_EN
  localparam int unsigned N = 8;
`else
  localparam int unsigned N = 7;
`endif
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]   state;
  logic [2:0]   bit_cnt;
  logic [N-1:0] code;

  logic [3:0] raw_data;
  logic [2:0] syn;
  logic [3:0] fixed_data;
  logic [3:0] dec_data;
  logic       dec_corr;
  logic       dec_err;

  logic [5:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        check_go;
  logic        push;
  logic        pop;
  logic [5:0]  head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      code    <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (serial_in) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          code[bit_cnt] <= serial_in;
          if (bit_cnt == 3'(N - 1)) state <= CHECK;
          else                      bit_cnt <= bit_cnt + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    raw_data   = code[3:0];
    syn[0]     = code[4] ^ code[3] ^ code[2] ^ code[0];
    syn[1]     = code[5] ^ code[3] ^ code[1] ^ code[0];
    syn[2]     = code[6] ^ code[2] ^ code[1] ^ code[0];
    fixed_data = raw_data;
    case (syn)
      3'b101:  fixed_data[2] = ~raw_data[2];
      3'b111:  fixed_data[0] = ~raw_data[0];
      3'b011:  fixed_data[3] = ~raw_data[3];
      3'b110:  fixed_data[1] = ~raw_data[1];
      default: fixed_data    = raw_data;
    endcase
    dec_data = raw_data;
    dec_corr = 1'b0;
    dec_err  = 1'b0;
`ifdef HAMMING_SECDED_EN
    // Overall parity separates single errors (incl. p0) from double errors.
    if (syn == 3'b000) begin
      dec_corr = ^code;
    end else if (^code) begin
      dec_corr = 1'b1;
      dec_data = fixed_data;
    end else begin
      dec_err = 1'b1;
    end
`else
    dec_corr = |syn;
    dec_data = fixed_data;
`endif
  end

  assign check_go = (state == CHECK) && enable;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = check_go && !full;
  assign pop      = dout.out_valid && dout.out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {dec_err, dec_corr, dec_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head               = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign dout.out_valid     = !empty;
  assign dout.out_error     = head[5];
  assign dout.out_corrected = head[4];
  assign dout.out_data      = head[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      corr_cnt <= '0;
    end else if (clr_cnt) begin
      overflow <= 1'b0;
      corr_cnt <= '0;
    end else if (check_go) begin
      if (full) overflow <= 1'b1;
      if (dec_corr && (corr_cnt != '1)) corr_cnt <= corr_cnt + 1'b1;
    end
  end

`ifdef HAMMING_SECDED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (check_go && dec_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Scoreboard bench for hamming_serial_rx: directed frames push expected
// entries; a negedge monitor pops and compares every accepted FIFO word.
module tb_hamming_serial_rx;
`ifdef HAMMING_SECDED_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       serial_in = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       overflow;
  logic [7:0] corr_cnt;
  logic [7:0] err_cnt;

  hamming_serial_rx_if bus ();

  hamming_serial_rx #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .serial_in (serial_in),
    .clr_cnt   (clr_cnt),
    .dout      (bus),
    .overflow  (overflow),
    .corr_cnt  (corr_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  logic [5:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted head against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none at %0t",
                   {bus.out_error, bus.out_corrected, bus.out_data}, $time);
        end else begin
          check("out_word", {26'b0, bus.out_error, bus.out_corrected, bus.out_data},
                {26'b0, exp_q.pop_front()});
        end
      end else if (!bus.out_valid) begin
        check("idle_zero", {29'b0, bus.out_error, bus.out_corrected, bus.out_data}, 0);
      end
    end
  end

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    c[3:0] = d;
    c[4]   = d[0] ^ d[2] ^ d[3];
    c[5]   = d[0] ^ d[1] ^ d[3];
    c[6]   = d[0] ^ d[1] ^ d[2];
    c[7]   = ^c[6:0];
    return c;
  endfunction

  task automatic send_frame(input logic [7:0] c, input logic stop, input bit toggle);
    logic [9:0] bits;
    bits = '0;
    bits[0] = 1'b1;
    for (int i = 0; i < NB; i++) bits[i+1] = c[i];
    bits[NB+1] = stop;
    for (int i = 0; i < NB + 2; i++) begin
      @(negedge clk);
      enable    = 1'b1;
      serial_in = bits[i];
      if (toggle) begin
        @(negedge clk);
        enable    = 1'b0;
        serial_in = ~bits[i];
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable    = 1'b1;
      serial_in = 1'b0;
    end
  endtask

  task automatic wait_drain;
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_corr", corr_cnt, 0);
    check("rst_err", err_cnt, 0);
    rst = 1'b1;
    idle(2);

    // 1: clean 4'hB frame and 2-cycle latency
    bus.out_ready = 1'b1;
    exp_q.push_back({2'b00, 4'hB});
    send_frame(8'h2B, 1'b0, 1'b0);
    check("lat_pre", bus.out_valid, 0);
    @(negedge clk);
    check("lat_post", bus.out_valid, 1);
    idle(3);
    wait_drain();

    // 2: d2 flipped (syndrome 101); stop sent as 1 must not start a frame
    exp_q.push_back({2'b01, 4'hB});
    send_frame(8'h2F, 1'b1, 1'b0);
    idle(14);
    wait_drain();
    check("corr_cnt_1", corr_cnt, 1);

    // 3: p2 flipped (syndrome 010)
    exp_q.push_back({2'b01, 4'hB});
    send_frame(8'h0B, 1'b0, 1'b0);
    idle(4);
    wait_drain();
    check("corr_cnt_2", corr_cnt, 2);

    // 4: d0 and d1 flipped, p0=0 (syndrome 001)
`ifdef HAMMING_SECDED_EN
    exp_q.push_back({2'b10, 4'h8});
`else
    exp_q.push_back({2'b01, 4'h8});
`endif
    send_frame(8'h28, 1'b0, 1'b0);
    idle(4);
    wait_drain();
`ifdef HAMMING_SECDED_EN
    check("corr_cnt_3", corr_cnt, 2);
    check("err_cnt_1", err_cnt, 1);
`else
    check("corr_cnt_3", corr_cnt, 3);
    check("err_cnt_0", err_cnt, 0);
`endif

    // 5: overflow with the consumer stalled
    bus.out_ready = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      if (d <= 4) exp_q.push_back({2'b00, 4'(d)});
      send_frame(enc(4'(d)), 1'b0, 1'b0);
      idle(1);
      if (d == 4) check("ovf_before", overflow, 0);
    end
    check("ovf_after", overflow, 1);
    check("hold_valid", bus.out_valid, 1);
    check("hold_data", bus.out_data, 1);
    bus.out_ready = 1'b1;
    wait_drain();
    idle(1);
    check("drained_valid", bus.out_valid, 0);
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("ovf_clr", overflow, 0);
    check("corr_clr", corr_cnt, 0);

    // 6: reset mid-frame, then a clean 4'h6 frame with gated enable
    begin
      logic [7:0] c9;
      c9 = enc(4'h9);
      @(negedge clk);
      enable = 1'b1;
      serial_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        serial_in = c9[i];
      end
      @(negedge clk);
      rst = 1'b0;
      enable = 1'b0;
      serial_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
    end
    idle(12);
    check("rst_partial", bus.out_valid, 0);
    exp_q.push_back({2'b00, 4'h6});
    send_frame(enc(4'h6), 1'b0, 1'b1);
    idle(4);
    wait_drain();
    check("corr_final", corr_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
